// File: rtl/uintm_alu_arbiter_pkg.sv
// Shared opcode and FSM encodings for the uintm ALU arbiter.
// Also provides a small opcode-legality helper.
package uintm_alu_arbiter_pkg;

   typedef logic [2:0] op_t;

   localparam op_t OP_ADD = 3'd0;
   localparam op_t OP_SUB = 3'd1;
   localparam op_t OP_MUL = 3'd2;
   localparam op_t OP_AND = 3'd3;
   localparam op_t OP_OR  = 3'd4;
   localparam op_t OP_XOR = 3'd5;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   function automatic logic op_legal(input op_t op);
      return (op <= OP_XOR);
   endfunction

endpackage

// File: rtl/uintm_alu_arbiter_if.sv
// Request/result bus between NREQ requesters, the arbiter and one result consumer.
// slave = arbiter side, master = requester/consumer side.
interface uintm_alu_arbiter_if #(
   parameter int BITS = 8,
   parameter int NREQ = 4
);
   localparam int ID_W = $clog2(NREQ);

   logic [NREQ-1:0]      req_valid;
   logic [3*NREQ-1:0]    req_op;
   logic [BITS*NREQ-1:0] req_x;
   logic [BITS*NREQ-1:0] req_y;
   logic [NREQ-1:0]      req_ready;
   logic                 res_valid;
   logic                 res_ready;
   logic [BITS-1:0]      res_data;
   logic [ID_W-1:0]      res_id;
   logic                 res_err;

   modport slave (
      input  req_valid, req_op, req_x, req_y, res_ready,
      output req_ready, res_valid, res_data, res_id, res_err
   );

   modport master (
      output req_valid, req_op, req_x, req_y, res_ready,
      input  req_ready, res_valid, res_data, res_id, res_err
   );
endinterface

// File: rtl/uintm_alu_arbiter_alu.sv
// Combinational modulo-2^BITS ALU: six operator leaves plus an opcode mux.
// Illegal opcodes produce zero with err_o set.
module uintm_add #(parameter int BITS = 8) (
   input  logic [BITS-1:0] a_i,
   input  logic [BITS-1:0] b_i,
   output logic [BITS-1:0] y_o
);
   assign y_o = a_i + b_i;
endmodule

module uintm_sub #(parameter int BITS = 8) (
   input  logic [BITS-1:0] a_i,
   input  logic [BITS-1:0] b_i,
   output logic [BITS-1:0] y_o
);
   assign y_o = a_i - b_i;
endmodule

module uintm_mul #(parameter int BITS = 8) (
   input  logic [BITS-1:0] a_i,
   input  logic [BITS-1:0] b_i,
   output logic [BITS-1:0] y_o
);
   assign y_o = a_i * b_i;
endmodule

module uintm_bit_and #(parameter int BITS = 8) (
   input  logic [BITS-1:0] a_i,
   input  logic [BITS-1:0] b_i,
   output logic [BITS-1:0] y_o
);
   assign y_o = a_i & b_i;
endmodule

module uintm_bit_or #(parameter int BITS = 8) (
   input  logic [BITS-1:0] a_i,
   input  logic [BITS-1:0] b_i,
   output logic [BITS-1:0] y_o
);
   assign y_o = a_i | b_i;
endmodule

module uintm_bit_xor #(parameter int BITS = 8) (
   input  logic [BITS-1:0] a_i,
   input  logic [BITS-1:0] b_i,
   output logic [BITS-1:0] y_o
);
   assign y_o = a_i ^ b_i;
endmodule

module uintm_alu
   import uintm_alu_arbiter_pkg::*;
#(
   parameter int BITS = 8
) (
   input  logic [BITS-1:0] x_i,
   input  logic [BITS-1:0] y_i,
   input  op_t             op_i,
   output logic [BITS-1:0] out_o,
   output logic            err_o
);
   logic [BITS-1:0] add_y, sub_y, mul_y, and_y, or_y, xor_y;

   uintm_add     #(.BITS(BITS)) u_add (.a_i(x_i), .b_i(y_i), .y_o(add_y));
   uintm_sub     #(.BITS(BITS)) u_sub (.a_i(x_i), .b_i(y_i), .y_o(sub_y));
   uintm_mul     #(.BITS(BITS)) u_mul (.a_i(x_i), .b_i(y_i), .y_o(mul_y));
   uintm_bit_and #(.BITS(BITS)) u_and (.a_i(x_i), .b_i(y_i), .y_o(and_y));
   uintm_bit_or  #(.BITS(BITS)) u_or  (.a_i(x_i), .b_i(y_i), .y_o(or_y));
   uintm_bit_xor #(.BITS(BITS)) u_xor (.a_i(x_i), .b_i(y_i), .y_o(xor_y));

   always_comb begin
      out_o = '0;
      err_o = !op_legal(op_i);
      case (op_i)
         OP_ADD:  out_o = add_y;
         OP_SUB:  out_o = sub_y;
         OP_MUL:  out_o = mul_y;
         OP_AND:  out_o = and_y;
         OP_OR:   out_o = or_y;
         OP_XOR:  out_o = xor_y;
         default: out_o = '0;
      endcase
   end
endmodule

// File: rtl/uintm_alu_arbiter.sv
// Round-robin arbiter in front of a shared ALU with a one-entry output register.
// Multiplies take an extra cycle (MUL state) using latched operands.
module uintm_alu_arbiter
   import uintm_alu_arbiter_pkg::*;
#(
   parameter int BITS = 8,
   parameter int NREQ = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   uintm_alu_arbiter_if.slave   bus
);
   localparam int ID_W = $clog2(NREQ);

   logic [1:0]      state_q, state_d;
   logic [ID_W-1:0] rr_q, rr_d;
   logic [BITS-1:0] x_q, x_d, y_q, y_d;
   logic [BITS-1:0] res_data_q, res_data_d;
   logic [ID_W-1:0] res_id_q, res_id_d;
   logic            res_err_q, res_err_d;

   op_t             op_a [NREQ];
   logic [BITS-1:0] x_a  [NREQ];
   logic [BITS-1:0] y_a  [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign op_a[g] = bus.req_op[3*g +: 3];
      assign x_a[g]  = bus.req_x[BITS*g +: BITS];
      assign y_a[g]  = bus.req_y[BITS*g +: BITS];
   end

   logic            win, found, accept;
   logic [ID_W-1:0] gnt_idx, idx_c;
   int              idx;
   op_t             sel_op, alu_op;
   logic [BITS-1:0] alu_x, alu_y, alu_out;
   logic            alu_err;
   int              rr_nxt;

   assign win = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.res_ready);

   // First valid requester at rr, rr+1, ... wins
   always_comb begin
      found         = 1'b0;
      gnt_idx       = '0;
      idx           = 0;
      idx_c         = '0;
      bus.req_ready = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx   = (int'(rr_q) + k) % NREQ;
         idx_c = idx[ID_W-1:0];
         if (!found && bus.req_valid[idx_c]) begin
            found   = 1'b1;
            gnt_idx = idx_c;
         end
      end
      if (win && found && !rst) bus.req_ready[gnt_idx] = 1'b1;
   end

   assign accept = |bus.req_ready;
   assign sel_op = op_a[gnt_idx];

   // In MUL the ALU sees the latched operands, otherwise the granted requester live
   assign alu_x  = (state_q == ST_MUL) ? x_q : x_a[gnt_idx];
   assign alu_y  = (state_q == ST_MUL) ? y_q : y_a[gnt_idx];
   assign alu_op = (state_q == ST_MUL) ? OP_MUL : sel_op;

   uintm_alu #(.BITS(BITS)) u_alu (
      .x_i   (alu_x),
      .y_i   (alu_y),
      .op_i  (alu_op),
      .out_o (alu_out),
      .err_o (alu_err)
   );

   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      x_d        = x_q;
      y_d        = y_q;
      res_data_d = res_data_q;
      res_id_d   = res_id_q;
      res_err_d  = res_err_q;
      rr_nxt     = (int'(gnt_idx) + 1) % NREQ;
      if (accept) begin
         rr_d     = rr_nxt[ID_W-1:0];
         res_id_d = gnt_idx;
         if (sel_op == OP_MUL) begin
            x_d     = x_a[gnt_idx];
            y_d     = y_a[gnt_idx];
            state_d = ST_MUL;
         end else begin
            res_data_d = alu_out;
            res_err_d  = alu_err;
            state_d    = ST_DONE;
         end
      end else begin
         case (state_q)
            ST_MUL: begin
               res_data_d = alu_out;
               res_err_d  = 1'b0;
               state_d    = ST_DONE;
            end
            ST_DONE: if (bus.res_ready) state_d = ST_IDLE;
            ST_IDLE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         rr_q       <= '0;
         res_data_q <= '0;
         res_id_q   <= '0;
         res_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         res_data_q <= res_data_d;
         res_id_q   <= res_id_d;
         res_err_q  <= res_err_d;
      end
   end

   // Operand latches carry no reset; they are only read in MUL after a load
   always_ff @(posedge clk) begin
      x_q <= x_d;
      y_q <= y_d;
   end

   assign bus.res_valid = (state_q == ST_DONE);
   assign bus.res_data  = res_data_q;
   assign bus.res_id    = res_id_q;
   assign bus.res_err   = res_err_q;
endmodule

// File: tb/tb_uintm_alu_arbiter.sv
// Directed bench for uintm_alu_arbiter with BITS=8, NREQ=4.
module tb_uintm_alu_arbiter;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   uintm_alu_arbiter_if #(.BITS(8), .NREQ(4)) u_if ();

   uintm_alu_arbiter #(.BITS(8), .NREQ(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] x,
                          input logic [7:0] y, input logic v);
      u_if.req_op[3*i +: 3] = op;
      u_if.req_x[8*i +: 8]  = x;
      u_if.req_y[8*i +: 8]  = y;
      u_if.req_valid[i]     = v;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      u_if.req_valid = 4'b1111;
      u_if.req_op    = '0;
      u_if.req_x     = '0;
      u_if.req_y     = '0;
      u_if.res_ready = 1'b1;
      step();
      step();
      chk("rst_valid", u_if.res_valid, 0);
      chk("rst_data",  u_if.res_data, 0);
      chk("rst_id",    u_if.res_id, 0);
      chk("rst_err",   u_if.res_err, 0);
      chk("rst_ready", u_if.req_ready, 4'b0000);
      u_if.req_valid = '0;
      rst = 1'b0;
      step();
      chk("idle_valid", u_if.res_valid, 0);

      // add: 200+100 = 300 mod 256 = 44
      set_req(0, 3'd0, 8'd200, 8'd100, 1'b1);
      #1 chk("add_grant", u_if.req_ready, 4'b0001);
      step();
      u_if.req_valid = '0;
      chk("add_valid", u_if.res_valid, 1);
      chk("add_data",  u_if.res_data, 44);
      chk("add_id",    u_if.res_id, 0);
      chk("add_err",   u_if.res_err, 0);
      step();
      chk("add_drain", u_if.res_valid, 0);

      // mul: 16*17 = 272 mod 256 = 16; operands altered after accept
      set_req(1, 3'd2, 8'd16, 8'd17, 1'b1);
      #1 chk("mul_grant", u_if.req_ready, 4'b0010);
      step();
      set_req(1, 3'd2, 8'd99, 8'd99, 1'b0);
      chk("mul_cycle_valid", u_if.res_valid, 0);
      step();
      chk("mul_valid", u_if.res_valid, 1);
      chk("mul_data",  u_if.res_data, 16);
      chk("mul_id",    u_if.res_id, 1);
      chk("mul_err",   u_if.res_err, 0);
      step();

      // sub: 3-5 wraps to 254, then illegal op back-to-back
      set_req(2, 3'd1, 8'd3, 8'd5, 1'b1);
      #1 chk("sub_grant", u_if.req_ready, 4'b0100);
      step();
      u_if.req_valid = '0;
      chk("sub_data", u_if.res_data, 254);
      chk("sub_id",   u_if.res_id, 2);
      set_req(3, 3'd7, 8'd9, 8'd9, 1'b1);
      #1 chk("ill_grant", u_if.req_ready, 4'b1000);
      step();
      u_if.req_valid = '0;
      chk("ill_valid", u_if.res_valid, 1);
      chk("ill_data",  u_if.res_data, 0);
      chk("ill_err",   u_if.res_err, 1);
      chk("ill_id",    u_if.res_id, 3);
      step();
      chk("ill_drain", u_if.res_valid, 0);

      // four continuous xor requesters: x=i+1, y=F0
      for (int i = 0; i < 4; i++) set_req(i, 3'd5, 8'(i + 1), 8'hF0, 1'b1);
      for (int k = 0; k < 6; k++) begin
         #1 chk("rr_grant", u_if.req_ready, 4'b0001 << (k % 4));
         step();
         chk("rr_valid", u_if.res_valid, 1);
         chk("rr_id",    u_if.res_id, k % 4);
         chk("rr_data",  u_if.res_data, 8'((k % 4) + 1) ^ 8'hF0);
      end

      // back-pressure: result from requester 1 must hold
      u_if.res_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1 chk("bp_ready", u_if.req_ready, 4'b0000);
         step();
         chk("bp_valid", u_if.res_valid, 1);
         chk("bp_data",  u_if.res_data, 8'hF2);
         chk("bp_id",    u_if.res_id, 1);
      end
      u_if.res_ready = 1'b1;
      #1 chk("bp_release_grant", u_if.req_ready, 4'b0100);
      step();
      chk("bp_release_id",   u_if.res_id, 2);
      chk("bp_release_data", u_if.res_data, 8'hF3);
      u_if.req_valid = '0;
      step();

      // reset during MUL discards the multiply and clears rr
      set_req(1, 3'd2, 8'd5, 8'd5, 1'b1);
      #1 chk("rmul_grant", u_if.req_ready, 4'b0010);
      step();
      u_if.req_valid = '0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rmul_valid", u_if.res_valid, 0);
      chk("rmul_data",  u_if.res_data, 0);
      step();
      chk("rmul_no_result", u_if.res_valid, 0);
      for (int i = 0; i < 4; i++) set_req(i, 3'd0, 8'd1, 8'd2, 1'b1);
      #1 chk("rmul_rr0", u_if.req_ready, 4'b0001);
      step();
      chk("rmul_after_id",   u_if.res_id, 0);
      chk("rmul_after_data", u_if.res_data, 3);
      u_if.req_valid = '0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uintm_alu_arbiter.md
UINTM_ALU_ARBITER -- requirements
Module: uintm_alu_arbiter

Interface
REQ-001 Parameter BITS, default 8, operand/result width in bits (1..64).
REQ-002 Parameter NREQ, default 4, number of requesters (2..8); ID_W = clog2(NREQ).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NREQ  per-requester operation request.
REQ-006 req_op  input  3*NREQ  packed opcode; requester i at bits [3i+2:3i].
REQ-007 req_x, req_y  input  BITS*NREQ  packed operands; requester i at bits [BITS*i+BITS-1:BITS*i].
REQ-008 req_ready  output  NREQ  one-hot grant; request i accepted when req_valid[i] and req_ready[i] are both high on an edge.
REQ-009 res_valid  output  1  result held in output register.
REQ-010 res_ready  input  1  consumer accepts result.
REQ-011 res_data  output  BITS  result value.
REQ-012 res_id  output  ID_W  index of the requester that owns the result.
REQ-013 res_err  output  1  illegal opcode flag for this result.

Function
REQ-014 Opcodes: 0 add, 1 sub, 2 mul, 3 and, 4 or, 5 xor; 6 and 7 are illegal.
REQ-015 All results are truncated modulo 2^BITS; sub wraps (3-5 = 2^BITS-2); mul keeps the low BITS bits only.
REQ-016 Illegal opcode: res_data=0, res_err=1, latency 1; otherwise res_err=0.
REQ-017 FSM states: IDLE (output empty), MUL (second multiply cycle), DONE (res_valid=1).
REQ-018 Accept window: state IDLE, or state DONE with res_ready=1; at most one request is accepted per cycle.
REQ-019 req_ready is combinational and never asserted outside the accept window or to a requester whose req_valid is low.
REQ-020 Round-robin arbitration: search starts at pointer rr; first valid requester at rr, rr+1, ... (mod NREQ) is granted.
REQ-021 rr becomes (granted+1) mod NREQ on each accept; rr is unchanged when nothing is accepted.
REQ-022 Non-mul accept: next state DONE, result registered; latency 1 cycle from accept edge to res_valid.
REQ-023 Mul accept: operands latched, next state MUL, then DONE; latency 2 cycles.
REQ-024 DONE with res_ready=1 and no accept: next state IDLE and res_valid=0.
REQ-025 DONE with res_ready=1 and an accept: the result is replaced without a bubble, so non-mul ops sustain one result per cycle.
REQ-026 Mul accepted from DONE: res_valid drops during MUL and re-asserts in DONE.
REQ-027 DONE with res_ready=0: res_data, res_id and res_err hold stable and req_ready stays all-zero.
REQ-028 Operands and opcode are sampled only at the accept edge; later changes to req_* have no effect on the result.

Reset
REQ-029 During rst: state IDLE, res_valid=0, res_data=0, res_id=0, res_err=0, rr=0, req_ready all-zero.
REQ-030 rst in any state, including MUL, discards the in-flight operation; no result for it is ever presented.
REQ-031 rst overrides a simultaneous accept and a simultaneous res_ready.

Structure
REQ-032 Opcode constants (OP_ADD..OP_XOR) and FSM state encodings shall live in the shared uintm package/include, not local to the module.
REQ-033 One combinational sub-module uintm_alu (x, y, op, out, err) shall instantiate uintm_add, uintm_sub, uintm_mul, uintm_bit_and, uintm_bit_or and uintm_bit_xor with an opcode mux.
REQ-034 The arbiter shall contain the FSM, the rr pointer, the operand latches and the output register only.

Verification (BITS=8, NREQ=4)
REQ-035 req0 add x=200 y=100, res_ready=1 -> one cycle after accept: res_valid=1, res_data=44, res_id=0, res_err=0.
REQ-036 req1 mul x=16 y=17 -> res_valid two cycles after accept, res_data=16, res_id=1.
REQ-037 All four requesters hold xor requests continuously, res_ready=1 -> grant order 0,1,2,3,0,1 with one result every cycle.
REQ-038 res_ready=0 for 5 cycles with a result pending -> res_data/res_id stable and req_ready=0000 throughout; on release, the next grant follows rr.
REQ-039 req2 sub x=3 y=5 -> res_data=254; req3 op=7 -> res_data=0, res_err=1.
REQ-040 rst asserted in the MUL cycle -> the next cycle shows res_valid=0 and rr=0, and no result is emitted for that operation.
